// File: rtl/connect4_pkg.sv
// Shared constants, cell codes and FSM state encoding for the connect-four move engine.
package connect4_pkg;

    localparam int ROWS      = 7;
    localparam int COLS      = 7;
    localparam int ROW_W     = 14;
    localparam int MAX_MOVES = 49;

    localparam logic [1:0] PLAYER_A = 2'b10;
    localparam logic [1:0] PLAYER_B = 2'b01;
    localparam logic [1:0] EMPTY    = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLACE,
        ST_SETTLE,
        ST_CHECK,
        ST_OVER
    } state_t;

    // Cell code written for the player whose turn it is (0 = A, 1 = B).
    function automatic logic [1:0] player_code(input logic turn);
        return turn ? PLAYER_B : PLAYER_A;
    endfunction

endpackage

// File: rtl/col_heights.sv
// Bank of per-column fill counters. The addressed column's height is presented
// combinationally; a column index past the board reads as full so the caller's
// legality test covers out-of-range requests as well.
module col_heights (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    input  logic [2:0] col,
    output logic [2:0] height,
    output logic       full
);
    import connect4_pkg::*;

    logic [2:0] h [COLS];

    // Count pieces per column; saturate at a full column.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < COLS; i++) begin
                h[i] <= 3'd0;
            end
        end else if (inc) begin
            for (int i = 0; i < COLS; i++) begin
                if (col == 3'(i) && h[i] != 3'(ROWS)) begin
                    h[i] <= h[i] + 3'd1;
                end
            end
        end
    end

    // Select the addressed column's height; unknown columns look full.
    always_comb begin
        height = 3'(ROWS);
        for (int i = 0; i < COLS; i++) begin
            if (col == 3'(i)) begin
                height = h[i];
            end
        end
    end

    assign full = (height == 3'(ROWS));

endmodule

// File: rtl/drop_piece.sv
// Connect-four move engine: accepts a column for the current player, drops the
// piece into the lowest empty cell, gives the external win checker one cycle to
// register the new board, then declares win, draw or next turn.
module drop_piece #(
    parameter int ROWS   = 7,
    parameter int COLS   = 7,
    parameter int CELL_W = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          drop_valid,
    input  logic [2:0]                    col_sel,
    output logic                          drop_ready,
    output logic                          illegal,
    output logic [ROWS*COLS*CELL_W-1:0]   grid,
    output logic [6:0]                    location,
    output logic                          turn,
    input  logic                          term,
    input  logic [1:0]                    winner,
    output logic                          game_over,
    output logic [1:0]                    game_winner,
    output logic                          draw,
    input  logic                          new_game
);
    import connect4_pkg::*;

    state_t     state;
    logic [2:0] col_q;
    logic [5:0] moves;

    logic [2:0] hc_col;
    logic [2:0] height;
    logic       full;
    logic       hc_inc;
    logic       hc_clear;
    logic       req_legal;
    logic [5:0] cell_idx;

    // In IDLE the counters are addressed by the request so legality can be
    // judged the same cycle; afterwards they follow the latched column.
    assign hc_col    = (state == ST_IDLE) ? col_sel : col_q;
    assign hc_inc    = (state == ST_PLACE);
    assign hc_clear  = (state == ST_OVER) && new_game;
    assign req_legal = (col_sel < 3'(COLS)) && !full;

    // Linear cell number r*7+c; doubling it and setting bit 0 gives the
    // high-bit index r*14+2c+1 that the checker expects as location.
    assign cell_idx  = ({3'b000, height} * 6'd7) + {3'b000, col_q};

    col_heights u_heights (
        .clk    (clk),
        .rst    (rst),
        .clear  (hc_clear),
        .inc    (hc_inc),
        .col    (hc_col),
        .height (height),
        .full   (full)
    );

    // Move FSM with the board and all status outputs registered alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            col_q       <= 3'd0;
            moves       <= 6'd0;
            grid        <= '0;
            location    <= 7'd1;
            turn        <= 1'b0;
            drop_ready  <= 1'b1;
            illegal     <= 1'b0;
            game_over   <= 1'b0;
            game_winner <= EMPTY;
            draw        <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (drop_valid) begin
                        if (req_legal) begin
                            col_q      <= col_sel;
                            drop_ready <= 1'b0;
                            state      <= ST_PLACE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end

                ST_PLACE: begin
                    grid[{cell_idx, 1'b0} +: CELL_W] <= player_code(turn);
                    location <= {cell_idx, 1'b1};
                    moves    <= moves + 6'd1;
                    state    <= ST_SETTLE;
                end

                // The checker registers the new board during this cycle.
                ST_SETTLE: begin
                    state <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (term) begin
                        game_winner <= winner;
                        game_over   <= 1'b1;
                        state       <= ST_OVER;
                    end else if (moves == 6'(MAX_MOVES)) begin
                        draw        <= 1'b1;
                        game_winner <= EMPTY;
                        game_over   <= 1'b1;
                        state       <= ST_OVER;
                    end else begin
                        turn       <= ~turn;
                        drop_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                ST_OVER: begin
                    if (new_game) begin
                        state       <= ST_IDLE;
                        col_q       <= 3'd0;
                        moves       <= 6'd0;
                        grid        <= '0;
                        location    <= 7'd1;
                        turn        <= 1'b0;
                        drop_ready  <= 1'b1;
                        game_over   <= 1'b0;
                        game_winner <= EMPTY;
                        draw        <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drop_piece.sv
// Bench for drop_piece: a behavioural win checker closes the loop, and a board
// model (2-D array, column heights, turn/move counters) predicts every outcome.
module tb_drop_piece;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        drop_valid = 1'b0;
    logic [2:0]  col_sel = 3'd0;
    logic        drop_ready;
    logic        illegal;
    logic [97:0] grid;
    logic [6:0]  location;
    logic        turn;
    logic        term;
    logic [1:0]  winner;
    logic        game_over;
    logic [1:0]  game_winner;
    logic        draw;
    logic        new_game = 1'b0;

    int checks = 0;
    int errors = 0;

    drop_piece dut (
        .clk         (clk),
        .rst         (rst),
        .drop_valid  (drop_valid),
        .col_sel     (col_sel),
        .drop_ready  (drop_ready),
        .illegal     (illegal),
        .grid        (grid),
        .location    (location),
        .turn        (turn),
        .term        (term),
        .winner      (winner),
        .game_over   (game_over),
        .game_winner (game_winner),
        .draw        (draw),
        .new_game    (new_game)
    );

    always #5 clk = ~clk;

    // ---------------- win checker (scans the whole board, registered) ----------
    function automatic bit any_four(input logic [97:0] g);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                for (int d = 0; d < 4; d++) begin
                    int rr = r + 3 * dr[d];
                    int cc = c + 3 * dc[d];
                    if (rr < 7 && cc >= 0 && cc < 7) begin
                        logic [1:0] v = g[(r * 7 + c) * 2 +: 2];
                        bit same = (v != 2'b00);
                        for (int k = 1; k < 4; k++)
                            if (g[((r + k * dr[d]) * 7 + c + k * dc[d]) * 2 +: 2] != v) same = 0;
                        if (same) return 1;
                    end
                end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            term   <= 1'b0;
            winner <= 2'b00;
        end else begin
            term   <= any_four(grid);
            winner <= grid[location -: 2];
        end
    end

    // ---------------- reference model -------------------------------------------
    int bd[7][7];
    int ht[7];
    int m_turn, m_moves, m_winner, m_loc;
    bit m_over, m_draw;

    task automatic model_reset();
        for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) bd[r][c] = 0;
        for (int c = 0; c < 7; c++) ht[c] = 0;
        m_turn = 0; m_moves = 0; m_winner = 0; m_loc = 1; m_over = 0; m_draw = 0;
    endtask

    function automatic logic [97:0] model_grid();
        logic [97:0] g = '0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                g[(r * 7 + c) * 2 +: 2] = 2'(bd[r][c]);
        return g;
    endfunction

    // Count the run through (r,c) in each of the four line directions.
    function automatic bit model_win(input int r, input int c);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        int who = bd[r][c];
        for (int d = 0; d < 4; d++) begin
            int n = 1;
            for (int s = -1; s <= 1; s += 2)
                for (int k = 1; k < 4; k++) begin
                    int rr = r + s * k * dr[d];
                    int cc = c + s * k * dc[d];
                    if (rr < 0 || rr > 6 || cc < 0 || cc > 6) break;
                    if (bd[rr][cc] != who) break;
                    n++;
                end
            if (n >= 4) return 1;
        end
        return 0;
    endfunction

    function automatic bit model_legal(input int c);
        return !m_over && c < 7 && ht[c] < 7;
    endfunction

    // ---------------- stimulus drivers (no checking) ----------------------------
    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_new_game();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
        if (m_over) model_reset();
    endtask

    // One request; lat = negedges from accept until drop_ready or game_over.
    // With noise set, drop_valid is held high on another column while busy.
    task automatic drive_drop(input int c, input bit noise,
                              output int lat, output bit ill_seen, output bit ill_after);
        bit legal = model_legal(c);
        int r;
        lat = 0; ill_after = 0;
        @(negedge clk); drop_valid = 1'b1; col_sel = 3'(c);
        @(negedge clk); drop_valid = 1'b0;
        ill_seen = illegal;
        if (!legal) begin
            @(negedge clk);
            ill_after = illegal;
            return;
        end
        lat = 1;
        if (noise) begin drop_valid = 1'b1; col_sel = 3'((c + 1) % 7); end
        while (!(drop_ready || game_over) && lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 3) drop_valid = 1'b0;
        end
        drop_valid = 1'b0;
        r = ht[c];
        bd[r][c] = (m_turn == 0) ? 2 : 1;
        ht[c]++;
        m_moves++;
        m_loc = r * 14 + 2 * c + 1;
        if (model_win(r, c)) begin
            m_over = 1; m_winner = bd[r][c];
        end else if (m_moves == 49) begin
            m_over = 1; m_draw = 1; m_winner = 0;
        end else begin
            m_turn = 1 - m_turn;
        end
    endtask

    // ---------------- tests ------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        checks++; if (grid !== '0) begin errors++; $display("FAIL reset_grid got %h want 0", grid); end
        checks++; if (location !== 7'd1) begin errors++; $display("FAIL reset_location got %0d want 1", location); end
        checks++; if (turn !== 1'b0) begin errors++; $display("FAIL reset_turn got %b want 0", turn); end
        checks++; if (drop_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", drop_ready); end
        checks++; if ({illegal, game_over, draw, game_winner} !== 5'b0) begin
            errors++; $display("FAIL reset_status got %b want 00000", {illegal, game_over, draw, game_winner}); end
    endtask

    task automatic test_first_drop();
        int lat; bit is, ia;
        apply_reset();
        drive_drop(3, 0, lat, is, ia);
        checks++; if (lat !== 4) begin errors++; $display("FAIL first_latency got %0d want 4", lat); end
        checks++; if (grid[7:6] !== 2'b10) begin errors++; $display("FAIL first_cell got %b want 10", grid[7:6]); end
        checks++; if (location !== 7'd7) begin errors++; $display("FAIL first_location got %0d want 7", location); end
        checks++; if (turn !== 1'b1) begin errors++; $display("FAIL first_turn got %b want 1", turn); end
        checks++; if (grid !== model_grid()) begin errors++; $display("FAIL first_grid got %h want %h", grid, model_grid()); end
    endtask

    task automatic test_vertical_win();
        int lat; bit is, ia;
        int seq[7] = '{0, 1, 0, 1, 0, 1, 0};
        logic [97:0] held;
        apply_reset();
        foreach (seq[i]) begin
            drive_drop(seq[i], 0, lat, is, ia);
            checks++; if (lat !== 4) begin errors++; $display("FAIL vwin_latency move %0d got %0d want 4", i, lat); end
        end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL vwin_over got %b want 1", game_over); end
        checks++; if (game_winner !== 2'b10) begin errors++; $display("FAIL vwin_winner got %b want 10", game_winner); end
        checks++; if (location !== 7'd43) begin errors++; $display("FAIL vwin_location got %0d want 43", location); end
        checks++; if ({draw, drop_ready} !== 2'b00) begin errors++; $display("FAIL vwin_draw_ready got %b want 00", {draw, drop_ready}); end
        held = grid;
        drive_drop(5, 0, lat, is, ia);
        checks++; if (grid !== held || is !== 1'b0) begin
            errors++; $display("FAIL over_ignores_drop got grid %h ill %b want %h ill 0", grid, is, held); end
        pulse_new_game();
        checks++; if (grid !== '0 || turn !== 1'b0 || drop_ready !== 1'b1 || game_over !== 1'b0 || location !== 7'd1 || game_winner !== 2'b00) begin
            errors++; $display("FAIL newgame_clear got grid %h turn %b ready %b over %b loc %0d win %b want all reset",
                               grid, turn, drop_ready, game_over, location, game_winner); end
    endtask

    task automatic test_full_column();
        int lat; bit is, ia;
        logic [97:0] held;
        apply_reset();
        for (int i = 0; i < 7; i++) drive_drop(2, 0, lat, is, ia);
        checks++; if (game_over !== 1'b0 || grid !== model_grid()) begin
            errors++; $display("FAIL fill_col2 got over %b grid %h want 0 %h", game_over, grid, model_grid()); end
        held = grid;
        drive_drop(2, 0, lat, is, ia);
        checks++; if (is !== 1'b1) begin errors++; $display("FAIL full_col_illegal got %b want 1", is); end
        checks++; if (ia !== 1'b0) begin errors++; $display("FAIL full_col_pulse_width got %b want 0", ia); end
        checks++; if (grid !== held || turn !== 1'(m_turn) || drop_ready !== 1'b1) begin
            errors++; $display("FAIL full_col_unchanged got turn %b ready %b want turn %0d ready 1", turn, drop_ready, m_turn); end
        drive_drop(7, 0, lat, is, ia);
        checks++; if (is !== 1'b1 || ia !== 1'b0) begin errors++; $display("FAIL col7_illegal got %b%b want 10", is, ia); end
        pulse_new_game();
        checks++; if (grid !== held || drop_ready !== 1'b1) begin errors++; $display("FAIL newgame_outside_over got %h want %h", grid, held); end
        drive_drop(3, 0, lat, is, ia);
        checks++; if (grid !== model_grid() || turn !== 1'(m_turn) || location !== 7'(m_loc)) begin
            errors++; $display("FAIL after_illegal_move got loc %0d turn %b want loc %0d turn %0d", location, turn, m_loc, m_turn); end
    endtask

    task automatic test_bottom_row_b();
        int lat; bit is, ia;
        int seq[8] = '{6, 0, 6, 1, 6, 2, 5, 3};
        apply_reset();
        foreach (seq[i]) drive_drop(seq[i], 0, lat, is, ia);
        checks++; if (game_over !== 1'b1 || game_winner !== 2'b01 || draw !== 1'b0) begin
            errors++; $display("FAIL row_win_b got over %b winner %b draw %b want 1 01 0", game_over, game_winner, draw); end
        checks++; if (location !== 7'd7) begin errors++; $display("FAIL row_win_location got %0d want 7", location); end
    endtask

    task automatic test_draw();
        int lat; bit is, ia;
        int order[7] = '{0, 2, 1, 3, 4, 6, 5};
        int early = 0;
        apply_reset();
        foreach (order[k])
            for (int i = 0; i < 7; i++) begin
                drive_drop(order[k], 0, lat, is, ia);
                if (lat != 4 || (m_moves < 49 && game_over)) early++;
            end
        checks++; if (early !== 0) begin errors++; $display("FAIL draw_progress got %0d bad moves want 0", early); end
        checks++; if (draw !== 1'b1 || game_winner !== 2'b00 || game_over !== 1'b1) begin
            errors++; $display("FAIL draw_result got draw %b winner %b over %b want 1 00 1", draw, game_winner, game_over); end
        checks++; if (grid !== model_grid()) begin errors++; $display("FAIL draw_grid got %h want %h", grid, model_grid()); end
        pulse_new_game();
        checks++; if (grid !== '0 || turn !== 1'b0 || drop_ready !== 1'b1 || draw !== 1'b0) begin
            errors++; $display("FAIL draw_newgame got grid %h turn %b ready %b draw %b want 0 0 1 0", grid, turn, drop_ready, draw); end
    endtask

    task automatic test_back_to_back();
        int lat; bit is, ia;
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_drop(i, 1, lat, is, ia);
            if (lat != 4 || grid !== model_grid()) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL busy_ignores_valid got %0d bad moves want 0", bad); end
        checks++; if (grid !== model_grid() || turn !== 1'(m_turn)) begin
            errors++; $display("FAIL busy_final got %h turn %b want %h turn %0d", grid, turn, model_grid(), m_turn); end
    endtask

    task automatic test_rst_mid_move();
        int lat; bit is, ia;
        int seq[6] = '{0, 1, 0, 1, 0, 1};
        apply_reset();
        foreach (seq[i]) drive_drop(seq[i], 0, lat, is, ia);
        @(negedge clk); drop_valid = 1'b1; col_sel = 3'd0;
        @(negedge clk); drop_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        checks++; if (grid !== '0 || location !== 7'd1 || turn !== 1'b0 || drop_ready !== 1'b1) begin
            errors++; $display("FAIL rst_settle_outputs got grid %h loc %0d turn %b ready %b want reset", grid, location, turn, drop_ready); end
        repeat (3) @(negedge clk);
        checks++; if (game_over !== 1'b0 || game_winner !== 2'b00 || drop_ready !== 1'b1) begin
            errors++; $display("FAIL rst_stale_term got over %b winner %b ready %b want 0 00 1", game_over, game_winner, drop_ready); end
    endtask

    task automatic test_random();
        int lat; bit is, ia;
        for (int g = 0; g < 5; g++) begin
            apply_reset();
            for (int n = 0; n < 80 && !m_over; n++) begin
                int c = $urandom_range(0, 7);
                bit exp_ill = !model_legal(c);
                drive_drop(c, bit'($urandom_range(0, 1)), lat, is, ia);
                checks++;
                if (is !== exp_ill || (!exp_ill && lat !== 4) || grid !== model_grid() || turn !== 1'(m_turn) ||
                    location !== 7'(m_loc) || game_over !== m_over || game_winner !== 2'(m_winner) || draw !== m_draw) begin
                    errors++;
                    $display("FAIL random g%0d n%0d col %0d got ill %b lat %0d loc %0d turn %b over %b win %b draw %b want ill %b loc %0d turn %0d over %b win %0d draw %b",
                             g, n, c, is, lat, location, turn, game_over, game_winner, draw, exp_ill, m_loc, m_turn, m_over, m_winner, m_draw);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_drop();
        test_vertical_win();
        test_full_column();
        test_bottom_row_b();
        test_draw();
        test_back_to_back();
        test_rst_mid_move();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
